fetch_decode_buffer: RTL and testbench

//  - 2-entry elastic IF/ID buffer between the instruction fetch stage and decode.
//  - Captures {pc, instruction} pairs from fetch, presents them to decode with valid/ready.
//  - Back-pressures fetch via in_ready, which drives the fetch PC-register enable.
//  - Discards wrong-path instructions on branch flush.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/ifid_entry_reg.sv | 27 ++
 rtl/fetch_decode_buffer.sv | 150 +++++++++++++++
 tb/tb_fetch_decode_buffer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF/ID buffer and its neighbours.
// The optional stall counter in the top is enabled with IFID_STALL_COUNT_EN.
package fetch_pkg;

  localparam int PC_W    = 18;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTRUCTION = 32'h0000_0000;
  localparam logic [15:0]        STALL_MAX       = 16'hFFFF;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/ifid_entry_reg.sv
// Load-enabled holding register for one {pc, instruction} entry of the IF/ID buffer.
// Cleared asynchronously so no stale entry survives a reset.
module ifid_entry_reg
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   i_load,
  input  entry_t i_d,
  output entry_t o_q
);

  entry_t r_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_decode_buffer.sv
// 2-entry elastic IF/ID buffer: head/tail entry registers plus an EMPTY/ONE/FULL FSM.
// Define IFID_STALL_COUNT_EN to add the saturating stall_count output.
module fetch_decode_buffer
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH          = PC_W,
  parameter int INSTRUCTION_WIDTH = INSTR_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [PC_WIDTH-1:0]          in_pc,
  input  logic [INSTRUCTION_WIDTH-1:0] in_instruction,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
  input  logic                         out_ready,
  input  logic                         flush
`ifdef IFID_STALL_COUNT_EN
  ,
  output logic [15:0]                  stall_count
`endif
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]          pc;
    logic [INSTRUCTION_WIDTH-1:0] instruction;
  } entry_t;

  buf_state_t r_state;
  buf_state_t w_state_next;
  logic       r_in_ready;
  logic       w_not_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_head_load;
  logic       w_tail_load;
  entry_t     w_in_entry;
  entry_t     w_head_d;
  entry_t     w_head_q;
  entry_t     w_tail_q;

  assign w_not_empty = (r_state != EMPTY);
  assign w_push      = in_valid & r_in_ready & ~flush;
  assign w_pop       = w_not_empty & out_ready;
  assign w_in_entry  = '{pc: in_pc, instruction: in_instruction};

  // in_ready is a flop tracking the next state, so it never depends on out_ready in-cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != FULL);
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) w_state_next = ONE;
        end
        ONE: begin
          if (w_push && !w_pop)      w_state_next = FULL;
          else if (w_pop && !w_push) w_state_next = EMPTY;
        end
        FULL: begin
          if (w_pop) w_state_next = ONE;
        end
        default: w_state_next = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready        = r_in_ready;
    out_valid       = w_not_empty;
    out_pc          = '0;
    out_instruction = INSTRUCTION_WIDTH'(NOP_INSTRUCTION);
    if (w_not_empty) begin
      out_pc          = w_head_q.pc;
      out_instruction = w_head_q.instruction;
    end
  end

  // On a simultaneous push/pop in ONE the new entry goes straight to the head
  always_comb begin
    w_head_load = 1'b0;
    w_tail_load = 1'b0;
    w_head_d    = w_in_entry;
    if (!flush) begin
      case (r_state)
        EMPTY: w_head_load = w_push;
        ONE: begin
          w_head_load = w_push & w_pop;
          w_tail_load = w_push & ~w_pop;
        end
        FULL: begin
          w_head_load = w_pop;
          w_head_d    = w_tail_q;
        end
        default: begin
          w_head_load = 1'b0;
        end
      endcase
    end
  end

  ifid_entry_reg #(
    .entry_t (entry_t)
  ) u_head (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_head_load),
    .i_d    (w_head_d),
    .o_q    (w_head_q)
  );

  ifid_entry_reg #(
    .entry_t (entry_t)
  ) u_tail (
    .clock  (clock),
    .reset  (reset),
    .i_load (w_tail_load),
    .i_d    (w_in_entry),
    .o_q    (w_tail_q)
  );

`ifdef IFID_STALL_COUNT_EN
  logic [15:0] r_stall_count;

  // Flush deliberately leaves the count alone; only reset clears it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_not_empty && !out_ready && (r_stall_count != STALL_MAX)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Scoreboard bench for fetch_decode_buffer; stall counter checks build only with IFID_STALL_COUNT_EN.
module tb_fetch_decode_buffer;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [17:0] in_pc;
  logic [31:0] in_instruction;
  logic        in_ready;
  logic        out_valid;
  logic [17:0] out_pc;
  logic [31:0] out_instruction;
  logic        out_ready;
  logic        flush;
`ifdef IFID_STALL_COUNT_EN
  logic [15:0] stall_count;
  logic [15:0] exp_stall;
`endif

  int checks   = 0;
  int failures = 0;

  logic [17:0] stim_q[$];
  logic [17:0] exp_q[$];

  fetch_decode_buffer dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_pc           (in_pc),
    .in_instruction  (in_instruction),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_pc          (out_pc),
    .out_instruction (out_instruction),
    .out_ready       (out_ready),
    .flush           (flush)
`ifdef IFID_STALL_COUNT_EN
    ,
    .stall_count     (stall_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] instr_of(input logic [17:0] pc);
    return 32'hC0DE_0000 ^ {14'h0, pc} ^ 32'h0000_5A01;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // One clock of stimulus: drive, compare against the model, then advance the model.
  task automatic cycle(input logic ordy, input logic fl);
    logic exp_rdy;
    logic exp_vld;
    logic push;
    logic pop;
    @(negedge clock);
    in_valid       = (stim_q.size() != 0);
    in_pc          = in_valid ? stim_q[0] : 18'h0;
    in_instruction = instr_of(in_pc);
    out_ready      = ordy;
    flush          = fl;
    #1;
    exp_rdy = (exp_q.size() < 2);
    exp_vld = (exp_q.size() != 0);
    check_val("in_ready", 64'(in_ready), 64'(exp_rdy));
    check_val("out_valid", 64'(out_valid), 64'(exp_vld));
`ifdef IFID_STALL_COUNT_EN
    check_val("stall_count", 64'(stall_count), 64'(exp_stall));
    if (exp_vld && !ordy && exp_stall != 16'hFFFF) exp_stall++;
`endif
    if (exp_vld) begin
      check_val("head_pc", 64'(out_pc), 64'(exp_q[0]));
      check_val("head_instr", 64'(out_instruction), 64'(instr_of(exp_q[0])));
    end else begin
      check_val("empty_pc", 64'(out_pc), 64'h0);
      check_val("empty_instr", 64'(out_instruction), 64'h0);
    end
    pop  = exp_vld && ordy;
    push = in_valid && exp_rdy && !fl;
    if (pop) $display("pop pc=%0d instr=%08h flush=%0b", out_pc, out_instruction, fl);
    if (fl) begin
      exp_q.delete();
      if (in_valid) void'(stim_q.pop_front());
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back(stim_q[0]);
        void'(stim_q.pop_front());
      end
    end
    @(posedge clock);
  endtask

  task automatic run(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cycle(ordy, 1'b0);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_val("rst_in_ready", 64'(in_ready), 64'h1);
    check_val("rst_out_valid", 64'(out_valid), 64'h0);
    check_val("rst_out_instr", 64'(out_instruction), 64'h0);
    check_val("rst_out_pc", 64'(out_pc), 64'h0);
    exp_q.delete();
    stim_q.delete();
`ifdef IFID_STALL_COUNT_EN
    exp_stall = '0;
`endif
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    in_valid       = 1'b0;
    in_pc          = '0;
    in_instruction = '0;
    out_ready      = 1'b0;
    flush          = 1'b0;
`ifdef IFID_STALL_COUNT_EN
    exp_stall      = '0;
`endif
    #1;
    check_val("init_in_ready", 64'(in_ready), 64'h1);
    check_val("init_out_valid", 64'(out_valid), 64'h0);
    check_val("init_out_instr", 64'(out_instruction), 64'h0);
    @(negedge clock);
    @(negedge clock);
    #2;
    reset = 1'b0;

    // streaming, out_ready always high
    for (int p = 0; p < 8; p++) stim_q.push_back(18'(p));
    run(10, 1'b1);

    // back-pressure then release
    stim_q.push_back(18'd10);
    stim_q.push_back(18'd11);
    stim_q.push_back(18'd12);
    run(5, 1'b0);
    run(5, 1'b1);

    // flush while FULL with an incoming instruction
    stim_q.push_back(18'd20);
    stim_q.push_back(18'd21);
    run(3, 1'b0);
    stim_q.push_back(18'd22);
    cycle(1'b0, 1'b1);
    run(3, 1'b1);

    // flush in ONE with concurrent push and pop
    stim_q.push_back(18'd25);
    cycle(1'b0, 1'b0);
    stim_q.push_back(18'd26);
    cycle(1'b1, 1'b1);
    run(2, 1'b1);

    // simultaneous push/pop in ONE
    stim_q.push_back(18'd30);
    cycle(1'b0, 1'b0);
    stim_q.push_back(18'd31);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    run(2, 1'b1);

    // reset with the buffer FULL, then confirm nothing leaks out
    stim_q.push_back(18'd40);
    stim_q.push_back(18'd41);
    run(3, 1'b0);
    async_reset();
    run(3, 1'b1);

`ifdef IFID_STALL_COUNT_EN
    async_reset();
    stim_q.push_back(18'd50);
    stim_q.push_back(18'd51);
    run(2, 1'b0);
    run(5, 1'b0);
    cycle(1'b0, 1'b1);
    run(3, 1'b0);
    stim_q.push_back(18'd52);
    run(70000, 1'b0);
    run(2, 1'b1);
    run(1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
